vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Owns the single-port 8-bit frame-buffer SRAM feeding the VGA colour stage. Interleaves scan-out
//  reads (hard priority, fixed slots) with pixel writes from a drawing client and a built-in
//  clear engine. Sits between the VGA timing generator (x_pos/y_pos/display_enable) and the
//  colour module. Output is RGB332 pixels; the 640x480 display is 2x2-upscaled from a 320x240 buffer.
// PARAMETERS
//  FB_W    320  buffer width in pixels (display width / 2)
//  FB_H    240  buffer height in lines (display height / 2)
//  RD_LAT  1    SRAM read latency, cycles from mem_re to valid mem_rdata (1..3)
// PORTS
//  clk             in   1   pixel clock, one display pixel per cycle
//  rst_n           in   1   asynchronous active-low reset
//  x_pos           in   10  current display column from timing generator
//  y_pos           in   10  current display line from timing generator
//  display_enable  in   1   high in active video region
//  pixel_out       out  8   RGB332 pixel to colour stage, 0 outside active video
//  wr_req          in   1   client write request, held until wr_ack
//  wr_addr         in   18  client linear buffer address
//  wr_data         in   8   client pixel data
//  wr_ack          out  1   one-cycle pulse: request consumed this cycle
//  wr_err          out  1   one-cycle pulse with wr_ack when wr_addr >= FB_W*FB_H
//  clear_req       in   1   pulse: start filling whole buffer with clear_color
//  clear_color     in   8   fill value, sampled on accepted clear_req
//  clear_busy      out  1   high while clear engine is active
//  mem_addr        out  18  SRAM address
//  mem_wdata       out  8   SRAM write data
//  mem_rdata       in   8   SRAM read data
//  mem_we          out  1   SRAM write strobe
//  mem_re          out  1   SRAM read strobe
//  mem_ce          out  1   SRAM chip enable = mem_we | mem_re
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; clear address counter 0; read pipeline flushed.
//  - All mem_* outputs registered; at most one of mem_we/mem_re high in any cycle.
//  - Scan slot: cycle with display_enable=1 and x_pos[0]=0 issues mem_re,
//    mem_addr = (y_pos>>1)*FB_W + (x_pos>>1). Constant multiply, 18-bit result, no truncation.
//  - Read data captured RD_LAT cycles after mem_re; pixel_out holds it two cycles (horizontal
//    doubling). pixel_out lags x_pos by RD_LAT+2 cycles; display_enable delayed identically gates it
//    (pixel_out=0 when delayed enable low). Downstream sync delay is matched by the timing generator.
//  - Free slot: any cycle not a scan slot (odd x, blanking). Free slots go to clear engine if
//    clear_busy, else to the client.
//  - FSM states: IDLE (client owns free slots), CLEAR (engine owns free slots).
//    IDLE -> CLEAR on clear_req: latch clear_color, address counter=0, clear_busy=1.
//    CLEAR: each free slot writes clear_color at counter, counter+1.
//    CLEAR -> IDLE after write to FB_W*FB_H-1; clear_busy drops the cycle after that write.
//  - clear_req while CLEAR: ignored (no restart, colour not re-latched).
//  - Client handshake: in IDLE, free slot with wr_req=1 -> mem_we with wr_addr/wr_data,
//    wr_ack=1 that cycle. Client drops or changes request the cycle after ack. No ack in CLEAR
//    or in scan slots; request just waits.
//  - Out-of-range wr_addr: wr_ack and wr_err pulse together, mem_we stays 0.
//  - clear_req and wr_req in same IDLE free slot: client write completes (acked), clear starts
//    next cycle.
//  - Reset mid-clear: engine aborts, buffer contents undefined, clear_busy=0.
//  - Worst-case active-line write bandwidth: one write per 2 cycles; full in blanking.
// TESTING
//  1. Reset mid-frame -> all outputs 0; first scan read at next even x with display_enable=1.
//  2. Preload addr 321=8'hE0; x_pos=2,y_pos=2, enable=1, RD_LAT=1 -> mem_re addr 321;
//     pixel_out=8'hE0 for 2 cycles starting 3 cycles later.
//  3. wr_req addr 5, data 8'h1C during active line -> ack only on odd-x cycle, mem_we there;
//     never coincident with mem_re.
//  4. wr_req addr 76800 -> wr_ack+wr_err same cycle, mem_we=0.
//  5. clear_req colour 8'h03 -> clear_busy high, 76800 writes of 8'h03 to addr 0..76799, pending
//     wr_req unacked until clear_busy falls, then acked on next free slot.
//  6. Assert rst_n=0 halfway through clear -> clear_busy=0 immediately, no further mem_we.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port frame-buffer SRAM owner for the VGA path.
// Interleaves fixed-slot scan-out reads with client writes and a clear engine.
//
// Ports:
//   clk, rst_n                        pixel clock, async active-low reset
//   x_pos, y_pos, display_enable      timing generator position and active-video flag
//   pixel_out                         RGB332 pixel, lags x_pos by RD_LAT+2 cycles
//   wr_req/wr_addr/wr_data            client write request (held until wr_ack)
//   wr_ack, wr_err                    request consumed / address out of range
//   clear_req, clear_color            start a whole-buffer fill
//   clear_busy                        fill in progress
//   mem_addr/mem_wdata/mem_rdata      SRAM address and data buses
//   mem_we/mem_re/mem_ce              SRAM strobes (registered)

module vga_fb_arbiter #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        display_enable,
    output logic [7:0]  pixel_out,
    input  logic        wr_req,
    input  logic [17:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    input  logic        clear_req,
    input  logic [7:0]  clear_color,
    output logic        clear_busy,
    output logic [17:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        mem_ce
);

    localparam int FB_N = FB_W * FB_H;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [17:0]       r_cnt;
    logic [7:0]        r_color;
    logic [17:0]       r_addr;
    logic [7:0]        r_wdata;
    logic              r_we;
    logic              r_re;
    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT+1:0] r_de;
    logic [7:0]        r_cap;

    logic              w_scan;
    logic              w_free;
    logic              w_last;
    logic              w_oob;
    logic              w_clr_go;
    logic              w_cli_go;
    logic              w_cli_wr;
    logic [17:0]       w_scan_addr;
    logic              w_unused;

    assign w_unused    = y_pos[0];
    assign w_scan      = display_enable & ~x_pos[0];
    assign w_free      = ~w_scan;
    assign w_last      = (r_cnt == 18'(FB_N - 1));
    assign w_oob       = (wr_addr >= 18'(FB_N));
    assign w_scan_addr = 18'(y_pos[9:1]) * 18'(FB_W) + 18'(x_pos[9:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (clear_req)         w_next = S_CLEAR;
            S_CLEAR: if (w_free && w_last)  w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_clr_go = 1'b0;
        w_cli_go = 1'b0;
        unique case (r_state)
            S_IDLE:  w_cli_go = w_free & wr_req;
            S_CLEAR: w_clr_go = w_free;
            default: ;
        endcase
    end

    // Acks are combinational in the free slot; the write lands on the
    // SRAM port the following cycle. Held off while reset is asserted.
    assign wr_ack     = rst_n & w_cli_go;
    assign wr_err     = wr_ack & w_oob;
    assign w_cli_wr   = w_cli_go & ~w_oob;
    assign clear_busy = (r_state == S_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_color <= '0;
        end else if (r_state == S_IDLE && clear_req) begin
            r_cnt   <= '0;
            r_color <= clear_color;
        end else if (w_clr_go) begin
            r_cnt   <= r_cnt + 18'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
        end else begin
            r_re <= w_scan;
            r_we <= w_clr_go | w_cli_wr;
            unique case (1'b1)
                w_scan:   r_addr <= w_scan_addr;
                w_clr_go: begin
                    r_addr  <= r_cnt;
                    r_wdata <= r_color;
                end
                w_cli_wr: begin
                    r_addr  <= wr_addr;
                    r_wdata <= wr_data;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign mem_re    = r_re;
    assign mem_ce    = r_we | r_re;

    // Read data is valid RD_LAT cycles after mem_re; the capture register
    // then holds it until the next scan read, giving the 2x horizontal repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_de  <= '0;
            r_cap <= '0;
        end else begin
            r_vld[0] <= r_re;
            for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
            r_de[0] <= display_enable;
            for (int i = 1; i < RD_LAT + 2; i++) r_de[i] <= r_de[i-1];
            if (r_vld[RD_LAT-1]) r_cap <= mem_rdata;
        end
    end

    assign pixel_out = r_de[RD_LAT+1] ? r_cap : 8'h00;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: self-checking bench for vga_fb_arbiter.
// Slot-level model checked every negedge plus hand-computed literals.

module tb_vga_fb_arbiter;

    localparam int FB_W = 320;
    localparam int FB_N = 76800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x_pos, y_pos;
    logic        display_enable;
    logic [7:0]  pixel_out;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack, wr_err;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ce;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.FB_W(320), .FB_H(240), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_pos(x_pos), .y_pos(y_pos), .display_enable(display_enable),
        .pixel_out(pixel_out),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ce(mem_ce)
    );

    logic [7:0] mem [0:FB_N-1];

    // SRAM model with 1-cycle read latency
    initial begin
        for (int i = 0; i < FB_N; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[321] = 8'hE0;
        mem_rdata <= 8'h00;
        forever begin
            @(posedge clk);
            if (mem_we && int'(mem_addr) < FB_N) mem[mem_addr] = mem_wdata;
            if (mem_re) mem_rdata <= (int'(mem_addr) < FB_N) ? mem[mem_addr] : 8'h00;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int saddr(input int x, input int y);
        return (y / 2) * FB_W + (x / 2);
    endfunction

    bit         m_busy;
    int         m_cnt;
    logic [7:0] m_color;
    bit         e_re, e_we;
    int         e_addr;
    logic [7:0] e_wdata;
    logic [7:0] last_val;
    logic [8:0] pq [$];
    bit         p_ok, p_de;
    int         p_x, p_y;

    always @(negedge clk) begin
        logic [8:0] ent;
        bit free, ea, ee, b0;
        if (!rst_n) begin
            chk("rst pixel_out", pixel_out, 0);
            chk("rst mem_ce", {mem_we, mem_re, mem_ce}, 0);
            chk("rst mem_addr", mem_addr, 0);
            chk("rst mem_wdata", mem_wdata, 0);
            chk("rst ack/err", {wr_ack, wr_err}, 0);
            chk("rst clear_busy", clear_busy, 0);
            m_busy = 0; m_cnt = 0; e_re = 0; e_we = 0;
            last_val = 0; p_ok = 0;
            pq = '{9'h0, 9'h0};
        end else begin
            chk("mem_re", mem_re, e_re);
            chk("mem_we", mem_we, e_we);
            chk("mem_ce", mem_ce, e_re | e_we);
            if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            chk("clear_busy", clear_busy, m_busy);
            if (p_ok && p_de && p_x[0] == 1'b0) last_val = mem[saddr(p_x, p_y)];
            pq.push_back({p_ok & p_de, last_val});
            ent = pq.pop_front();
            chk("pixel_out", pixel_out, ent[8] ? ent[7:0] : 8'h00);
            free = !(display_enable && !x_pos[0]);
            ea = wr_req && free && !m_busy;
            ee = ea && int'(wr_addr) >= FB_N;
            chk("wr_ack", wr_ack, ea);
            chk("wr_err", wr_err, ee);
            b0 = m_busy;
            e_re = 0; e_we = 0;
            if (!free) begin
                e_re = 1; e_addr = saddr(int'(x_pos), int'(y_pos));
            end else if (b0) begin
                e_we = 1; e_addr = m_cnt; e_wdata = m_color;
                m_cnt++;
                if (m_cnt == FB_N) m_busy = 0;
            end else if (ea && !ee) begin
                e_we = 1; e_addr = int'(wr_addr); e_wdata = wr_data;
            end
            if (!b0 && clear_req) begin
                m_busy = 1; m_cnt = 0; m_color = clear_color;
            end
            p_ok = 1; p_de = display_enable;
            p_x = int'(x_pos); p_y = int'(y_pos);
        end
    end

    logic        s_ack, s_err, s_re, s_we, s_busy;
    logic [17:0] s_addr;
    logic [7:0]  s_wdata, s_pix;
    logic [7:0]  pix_l [0:9];

    task automatic drv(input bit de, input int x, input int y);
        display_enable = de;
        x_pos = x[9:0];
        y_pos = y[9:0];
        #1;
        s_ack = wr_ack;
        s_err = wr_err;
        @(posedge clk);
        #1;
        s_re = mem_re; s_we = mem_we; s_addr = mem_addr;
        s_wdata = mem_wdata; s_pix = pixel_out; s_busy = clear_busy;
    endtask

    initial begin
        int ack_x, clr_w;
        bit got;
        logic busy_at_ack;
        rst_n = 0; display_enable = 0; x_pos = 0; y_pos = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0;
        clear_req = 0; clear_color = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // scan read of line 2: addr 321 preloaded with E0
        for (int i = 0; i < 10; i++) begin
            drv(1, i, 2);
            pix_l[i] = s_pix;
            if (i == 2) begin
                chk("t2 mem_re", s_re, 1);
                chk("t2 mem_addr", s_addr, 321);
            end
        end
        chk("t2 pix c5", pix_l[4], 8'hE0);
        chk("t2 pix c6", pix_l[5], 8'hE0);
        chk("t2 pix c7", pix_l[6], 8'h18);
        repeat (4) drv(0, 700, 2);

        // reset mid-frame, then resume at odd x
        for (int i = 0; i < 3; i++) drv(1, i, 10);
        #1 rst_n = 0;
        #1;
        chk("t1 async pix", pixel_out, 0);
        chk("t1 async ce", mem_ce, 0);
        drv(1, 3, 10);
        drv(1, 4, 10);
        rst_n = 1;
        drv(1, 5, 10);
        chk("t1 no re odd", s_re, 0);
        drv(1, 6, 10);
        chk("t1 first re", s_re, 1);
        chk("t1 first addr", s_addr, 1603);
        repeat (4) drv(0, 700, 10);

        // client write during active line
        wr_req = 1; wr_addr = 5; wr_data = 8'h1C;
        ack_x = -1;
        for (int i = 0; i < 10; i++) begin
            drv(1, i, 200);
            if (s_ack && ack_x < 0) begin
                ack_x = i;
                chk("t3 we after ack", s_we, 1);
                chk("t3 we addr", s_addr, 5);
                chk("t3 we data", s_wdata, 8'h1C);
                wr_req = 0;
            end
        end
        chk("t3 ack x", ack_x, 1);
        repeat (3) drv(0, 700, 200);
        chk("t3 mem[5]", mem[5], 8'h1C);

        // out-of-range write
        wr_req = 1; wr_addr = 18'd76800; wr_data = 8'hFF;
        drv(0, 700, 200);
        chk("t4 ack", s_ack, 1);
        chk("t4 err", s_err, 1);
        chk("t4 no we", s_we, 0);
        wr_req = 0;
        drv(0, 700, 200);

        // full clear with pending client write
        clear_req = 1; clear_color = 8'h03;
        drv(0, 700, 50);
        clear_req = 0;
        chk("t5 busy", s_busy, 1);
        wr_req = 1; wr_addr = 7; wr_data = 8'hAA;
        clr_w = 0; got = 0; busy_at_ack = 1'b1;
        for (int n = 0; n < 80000 && !got; n++) begin
            busy_at_ack = s_busy;
            if (n < 64) drv(1, n, 50);
            else        drv(0, 700, 50);
            if (s_ack) begin
                got = 1;
                wr_req = 0;
                chk("t5 busy at ack", busy_at_ack, 0);
                chk("t5 cli we", s_we, 1);
                chk("t5 cli addr", s_addr, 7);
                chk("t5 cli data", s_wdata, 8'hAA);
            end else if (s_we && s_wdata == 8'h03) begin
                clr_w++;
            end
        end
        chk("t5 acked", got, 1);
        chk("t5 clear writes", clr_w, 76800);
        repeat (3) drv(0, 700, 50);
        chk("t5 mem[0]", mem[0], 8'h03);
        chk("t5 mem[5]", mem[5], 8'h03);
        chk("t5 mem[38400]", mem[38400], 8'h03);
        chk("t5 mem[76799]", mem[76799], 8'h03);
        chk("t5 mem[7]", mem[7], 8'hAA);

        // reset halfway into a second clear
        clear_req = 1; clear_color = 8'h55;
        drv(0, 700, 0);
        clear_req = 0;
        repeat (500) drv(0, 700, 0);
        #1 rst_n = 0;
        #1;
        chk("t6 busy drop", clear_busy, 0);
        chk("t6 we drop", mem_we, 0);
        drv(0, 700, 0);
        drv(0, 700, 0);
        rst_n = 1;
        clr_w = 0;
        repeat (20) begin
            drv(0, 700, 0);
            if (s_we) clr_w++;
        end
        chk("t6 no writes", clr_w, 0);
        chk("t6 busy idle", s_busy, 0);
        chk("t6 mem[0]", mem[0], 8'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
